// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the packet-locked round-robin arbiter.
package noc_arb_pkg;

    // Arbiter FSM: IDLE (no grant) or LOCKED (grant held until packet end)
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Ceiling log2, never less than 1 so derived widths stay legal
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Binary index of the set bit of a one-hot vector (0 when empty)
    function automatic logic [31:0] onehot_to_idx(input logic [31:0] onehot);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

    // Rotate the low 'width' bits of vec left by amt
    function automatic logic [31:0] rotl(input logic [31:0] vec, input int amt, input int width);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < width; i++) begin
            if (vec[i]) res[(i + amt) % width] = 1'b1;
        end
        return res;
    endfunction

    // Rotate the low 'width' bits of vec right by amt
    function automatic logic [31:0] rotr(input logic [31:0] vec, input int amt, input int width);
        return rotl(vec, width - (amt % width), width);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of vec at or above start, wrapping.
// Thermometer mask selects the upper half; if it is empty, the plain
// lowest-set-bit of the whole vector is the wrapped winner.
module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int WORD_WIDTH = 4,
    parameter int IDX_W      = clog2(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0] vec,
    input  logic [IDX_W-1:0]      start,
    output logic [WORD_WIDTH-1:0] winner,
    output logic                  found
);

    logic [WORD_WIDTH-1:0] mask;
    logic [WORD_WIDTH-1:0] masked;
    logic [WORD_WIDTH-1:0] low_masked;
    logic [WORD_WIDTH-1:0] low_all;

    // Two priority pickers: one over the masked upper range, one over all bits
    always_comb begin
        mask = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            mask[i] = (IDX_W'(i) >= start);
        end
        masked     = vec & mask;
        low_masked = masked & (~masked + 1'b1);
        low_all    = vec & (~vec + 1'b1);
        winner     = (|masked) ? low_masked : low_all;
        found      = |vec;
    end

endmodule

// File: rtl/rr_arbiter_lock.sv
// Packet-locked round-robin arbiter for one crossbar output port.
// Handshake: a beat of the granted requester g moves when reqs[g] & ready;
// the lock is released by that beat carrying last[g], or by the hold timeout.
module rr_arbiter_lock
    import noc_arb_pkg::*;
#(
    parameter int  WORD_WIDTH = 4,
    parameter int  MAX_HOLD   = 0,
    localparam int IDX_W      = clog2(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] reqs,
    input  logic [WORD_WIDTH-1:0] last,
    input  logic                  ready,
    output logic [WORD_WIDTH-1:0] grants,
    output logic                  grant_valid,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  hold_timeout
);

    localparam int HC_W = clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(WORD_WIDTH - 1);

    arb_state_e            state, state_nxt;
    logic [IDX_W-1:0]      ptr_q, ptr_nxt;
    logic [WORD_WIDTH-1:0] grants_q, grants_nxt;
    logic                  valid_q, valid_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    logic                  to_q, to_nxt;
    logic [HC_W-1:0]       cnt_q, cnt_nxt;

    logic                  xfer_last;
    logic                  timeout_hit;
    logic                  release_now;
    logic [IDX_W-1:0]      start_idle, start_rel;
    logic [WORD_WIDTH-1:0] idle_win, rel_win;
    logic                  idle_found, rel_found;

    // Scan start points: one past the pointer (IDLE) or past the holder (release)
    assign start_idle = (ptr_q == TOP_IDX) ? '0 : ptr_q + 1'b1;
    assign start_rel  = (idx_q == TOP_IDX) ? '0 : idx_q + 1'b1;

    rr_pick #(.WORD_WIDTH(WORD_WIDTH), .IDX_W(IDX_W)) u_pick_idle (
        .vec    (reqs),
        .start  (start_idle),
        .winner (idle_win),
        .found  (idle_found)
    );

    // The releasing holder is masked out so it cannot win back-to-back
    rr_pick #(.WORD_WIDTH(WORD_WIDTH), .IDX_W(IDX_W)) u_pick_rel (
        .vec    (reqs & ~grants_q),
        .start  (start_rel),
        .winner (rel_win),
        .found  (rel_found)
    );

    // Release decode: last beat accepted, else timeout on the final hold cycle
    always_comb begin
        xfer_last   = ready & (|(grants_q & reqs & last));
        timeout_hit = (MAX_HOLD != 0) && (state == LOCKED) && (cnt_q == HOLD_LAST) && !xfer_last;
        release_now = (state == LOCKED) && (xfer_last || timeout_hit);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (idle_found) state_nxt = LOCKED;
            LOCKED:  if (release_now && !rel_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next grant, pointer, hold counter and timeout pulse
    always_comb begin
        grants_nxt = grants_q;
        idx_nxt    = idx_q;
        ptr_nxt    = ptr_q;
        cnt_nxt    = cnt_q;
        to_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (idle_found) begin
                    grants_nxt = idle_win;
                    idx_nxt    = IDX_W'(onehot_to_idx(32'(idle_win)));
                    ptr_nxt    = idx_nxt;
                    cnt_nxt    = '0;
                end
            end
            LOCKED: begin
                if (release_now) begin
                    to_nxt  = timeout_hit;
                    cnt_nxt = '0;
                    if (rel_found) begin
                        grants_nxt = rel_win;
                        idx_nxt    = IDX_W'(onehot_to_idx(32'(rel_win)));
                        ptr_nxt    = idx_nxt;
                    end else begin
                        grants_nxt = '0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            default: grants_nxt = '0;
        endcase
        valid_nxt = |grants_nxt;
    end

    // Registered outputs and arbitration state
    always_ff @(posedge clk) begin
        if (rst) begin
            grants_q <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= TOP_IDX;
        end else begin
            grants_q <= grants_nxt;
            valid_q  <= valid_nxt;
            idx_q    <= idx_nxt;
            to_q     <= to_nxt;
            cnt_q    <= cnt_nxt;
            ptr_q    <= ptr_nxt;
        end
    end

    // Output drive
    assign grants       = grants_q;
    assign grant_valid  = valid_q;
    assign grant_idx    = idx_q;
    assign hold_timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter_lock.sv
// Bench for rr_arbiter_lock: cycle tables for WORD_WIDTH=4 (no timeout and
// MAX_HOLD=5) plus a rotation/wrap sweep at WORD_WIDTH=2,5,8.
module tb_rr_arbiter_lock;

    typedef struct {
        logic       rst;
        logic [3:0] reqs;
        logic [3:0] last;
        logic       ready;
        logic [3:0] exp_grants;
        logic [1:0] exp_idx;
        logic       exp_to;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Clock and shared stimulus
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] reqs, last;
    logic       ready;
    logic       sw_rst, sw_on;

    always #5 clk = ~clk;

    // Main DUT (no timeout) and timeout DUT, same stimulus
    logic [3:0] a_grants, t_grants;
    logic       a_valid, t_valid, a_to, t_to;
    logic [1:0] a_idx, t_idx;

    rr_arbiter_lock #(.WORD_WIDTH(4), .MAX_HOLD(0)) u_dut (
        .clk(clk), .rst(rst), .reqs(reqs), .last(last), .ready(ready),
        .grants(a_grants), .grant_valid(a_valid), .grant_idx(a_idx), .hold_timeout(a_to));

    rr_arbiter_lock #(.WORD_WIDTH(4), .MAX_HOLD(5)) u_dut_to (
        .clk(clk), .rst(rst), .reqs(reqs), .last(last), .ready(ready),
        .grants(t_grants), .grant_valid(t_valid), .grant_idx(t_idx), .hold_timeout(t_to));

    // Width sweep instances, all requesters sending 1-beat packets
    logic [1:0] g2;  logic v2, to2;  logic [0:0] i2;
    logic [4:0] g5;  logic v5, to5;  logic [2:0] i5;
    logic [7:0] g8;  logic v8, to8;  logic [2:0] i8;

    rr_arbiter_lock #(.WORD_WIDTH(2)) u_w2 (
        .clk(clk), .rst(sw_rst), .reqs({2{sw_on}}), .last({2{sw_on}}), .ready(sw_on),
        .grants(g2), .grant_valid(v2), .grant_idx(i2), .hold_timeout(to2));
    rr_arbiter_lock #(.WORD_WIDTH(5)) u_w5 (
        .clk(clk), .rst(sw_rst), .reqs({5{sw_on}}), .last({5{sw_on}}), .ready(sw_on),
        .grants(g5), .grant_valid(v5), .grant_idx(i5), .hold_timeout(to5));
    rr_arbiter_lock #(.WORD_WIDTH(8)) u_w8 (
        .clk(clk), .rst(sw_rst), .reqs({8{sw_on}}), .last({8{sw_on}}), .ready(sw_on),
        .grants(g8), .grant_valid(v8), .grant_idx(i8), .hold_timeout(to8));

    vec_t tab_a[31];
    vec_t tab_t[13];

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] ls,
                                input logic rd, input logic [3:0] eg, input logic [1:0] ei,
                                input logic et);
        vec_t v;
        v.rst = r; v.reqs = rq; v.last = ls; v.ready = rd;
        v.exp_grants = eg; v.exp_idx = ei; v.exp_to = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; reqs = v.reqs; last = v.last; ready = v.ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; reqs = '0; last = '0; ready = 1'b0;
        sw_rst = 1'b1; sw_on = 1'b0;

        // Main table: rst, reqs, last, ready -> grants, idx, timeout pulse
        tab_a[0]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0); // reset
        tab_a[1]  = mk(0, 4'b1010, 4'b1111, 1, 4'b0010, 1, 0); // first grant, req0 first in line but idle
        tab_a[2]  = mk(0, 4'b1010, 4'b1111, 1, 4'b1000, 3, 0); // no bubble
        tab_a[3]  = mk(0, 4'b1010, 4'b1111, 1, 4'b0010, 1, 0);
        tab_a[4]  = mk(0, 4'b0010, 4'b0010, 1, 4'b0000, 1, 0); // release, nobody else -> idle, idx holds
        tab_a[5]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
        tab_a[6]  = mk(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, 0); // req0 3-beat packet
        tab_a[7]  = mk(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 0); // beat 1
        tab_a[8]  = mk(0, 4'b0101, 4'b0001, 0, 4'b0001, 0, 0); // last without ready ignored
        tab_a[9]  = mk(0, 4'b0101, 4'b0000, 1, 4'b0001, 0, 0); // beat 2
        tab_a[10] = mk(0, 4'b0101, 4'b0001, 1, 4'b0100, 2, 0); // beat 3 last -> req2, no bubble
        tab_a[11] = mk(0, 4'b0110, 4'b0100, 1, 4'b0010, 1, 0); // req2 done -> req1
        tab_a[12] = mk(0, 4'b0110, 4'b0000, 1, 4'b0010, 1, 0);
        tab_a[13] = mk(0, 4'b0100, 4'b0010, 1, 4'b0010, 1, 0); // req1 drops, last ignored
        tab_a[14] = mk(0, 4'b0100, 4'b0010, 1, 4'b0010, 1, 0);
        tab_a[15] = mk(0, 4'b0110, 4'b0000, 1, 4'b0010, 1, 0); // resumes
        tab_a[16] = mk(0, 4'b0110, 4'b0010, 1, 4'b0100, 2, 0); // last -> req2
        tab_a[17] = mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 2, 0);
        tab_a[18] = mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 0); // lone requester: grant/idle alternate
        tab_a[19] = mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 2, 0);
        tab_a[20] = mk(0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 0);
        tab_a[21] = mk(0, 4'b0100, 4'b0100, 1, 4'b0000, 2, 0);
        tab_a[22] = mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 0); // ptr=2 -> req3
        tab_a[23] = mk(0, 4'b1111, 4'b0000, 1, 4'b1000, 3, 0);
        tab_a[24] = mk(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0); // reset mid-lock
        tab_a[25] = mk(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0);
        tab_a[26] = mk(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0); // fair rotation
        tab_a[27] = mk(0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 0);
        tab_a[28] = mk(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 0);
        tab_a[29] = mk(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0);
        tab_a[30] = mk(0, 4'b0000, 4'b0000, 1, 4'b0001, 0, 0); // holder idle: lock held

        // Timeout table (MAX_HOLD=5)
        tab_t[0]  = mk(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0);
        tab_t[1]  = mk(0, 4'b1000, 4'b0000, 1, 4'b1000, 3, 0);
        for (int i = 2; i <= 5; i++) tab_t[i] = mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 3, 0);
        tab_t[6]  = mk(0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 1); // forced release after 5 cycles
        for (int i = 7; i <= 10; i++) tab_t[i] = mk(0, 4'b1001, 4'b0000, 1, 4'b0001, 0, 0);
        tab_t[11] = mk(0, 4'b1001, 4'b0001, 1, 4'b1000, 3, 0); // last on timeout cycle: no pulse
        tab_t[12] = mk(0, 4'b1001, 4'b0000, 1, 4'b1000, 3, 0);

        for (int i = 0; i < 31; i++) begin
            apply(tab_a[i]);
            check($sformatf("a%0d_grants", i), 32'(a_grants), 32'(tab_a[i].exp_grants));
            check($sformatf("a%0d_valid", i), 32'(a_valid), 32'(|tab_a[i].exp_grants));
            check($sformatf("a%0d_idx", i), 32'(a_idx), 32'(tab_a[i].exp_idx));
            check($sformatf("a%0d_timeout", i), 32'(a_to), 32'(tab_a[i].exp_to));
        end

        for (int i = 0; i < 13; i++) begin
            apply(tab_t[i]);
            check($sformatf("t%0d_grants", i), 32'(t_grants), 32'(tab_t[i].exp_grants));
            check($sformatf("t%0d_valid", i), 32'(t_valid), 32'(|tab_t[i].exp_grants));
            check($sformatf("t%0d_idx", i), 32'(t_idx), 32'(tab_t[i].exp_idx));
            check($sformatf("t%0d_timeout", i), 32'(t_to), 32'(tab_t[i].exp_to));
        end

        // Width sweep: reset, then grants rotate one per cycle and wrap
        sw_rst = 1'b1; sw_on = 1'b1;
        @(posedge clk); #1;
        check("w2_reset", 32'(g2), 32'd0);
        check("w5_reset", 32'(g5), 32'd0);
        check("w8_reset", 32'(g8), 32'd0);
        sw_rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            check($sformatf("w2_grants_%0d", k), 32'(g2), 32'(1) << (k % 2));
            check($sformatf("w5_grants_%0d", k), 32'(g5), 32'(1) << (k % 5));
            check($sformatf("w8_grants_%0d", k), 32'(g8), 32'(1) << (k % 8));
            check($sformatf("w5_idx_%0d", k), 32'(i5), 32'(k % 5));
            check($sformatf("w8_idx_%0d", k), 32'(i8), 32'(k % 8));
            check($sformatf("w8_valid_%0d", k), 32'(v8), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
